// File: rtl/cnt_pkg.sv
// cnt_pkg: shared mode/direction constants and load clamp for the counter family.
package cnt_pkg;
    localparam bit CNT_WRAP = 1'b0;
    localparam bit CNT_SAT  = 1'b1;
    localparam bit UP       = 1'b0;
    localparam bit DN       = 1'b1;

    function automatic logic [31:0] clamp(input logic [31:0] d, input logic [31:0] top);
        return (d > top) ? top : d;
    endfunction
endpackage

// File: rtl/updncnt_bnd.sv
// updncnt_bnd: combinational bound detect, at zero when counting down and at TOP when counting up.
module updncnt_bnd import cnt_pkg::*; #(
    parameter int          WIDTH = 8,
    parameter int unsigned TOP   = 32'((64'd1 << WIDTH) - 64'd1)
) (
    input  logic [WIDTH-1:0] q,
    input  logic             dn,
    output logic             bnd
);
    localparam logic [WIDTH-1:0] TOPW = WIDTH'(TOP);

    always_comb bnd = (dn == DN) ? (q == '0) : (q == TOPW);
endmodule

// File: rtl/updncnt.sv
// updncnt: loadable up/down counter with programmable terminal value, wrap/saturate mode,
// combinational carry out for cascading and a registered terminal-count pulse.
module updncnt import cnt_pkg::*; #(
    parameter int          WIDTH = 8,
    parameter int unsigned TOP   = 32'((64'd1 << WIDTH) - 64'd1),
    parameter bit          SAT   = CNT_WRAP
) (
    input  logic             clk,
    input  logic             resl,
    input  logic             ci,
    input  logic             dn,
    input  logic             ld,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             co,
    output logic             tcq
);
    localparam logic [WIDTH-1:0] TOPW = WIDTH'(TOP);

    logic [WIDTH-1:0] q_q, q_d;
    logic             tcq_q, tcq_d;
    logic             bnd;

    updncnt_bnd #(.WIDTH(WIDTH), .TOP(TOP)) u_bnd (
        .q   (q_q),
        .dn  (dn),
        .bnd (bnd)
    );

    always_comb begin
        co    = resl & ~ld & ci & bnd;
        tcq_d = co;
        // At the bound: saturate holds, wrap jumps to the opposite end of the range
        q_d   = ld   ? WIDTH'(clamp(32'(d), 32'(TOP))) :
                !ci  ? q_q :
                !bnd ? ((dn == DN) ? q_q - WIDTH'(1) : q_q + WIDTH'(1)) :
                SAT  ? q_q :
                ((dn == DN) ? TOPW : '0);
    end

    always_ff @(posedge clk) begin
        if (!resl) begin
            q_q   <= '0;
            tcq_q <= 1'b0;
        end else begin
            q_q   <= q_d;
            tcq_q <= tcq_d;
        end
    end

    assign q   = q_q;
    assign tcq = tcq_q;
endmodule

// File: tb/tb_updncnt.sv
// tb_updncnt: randomized scoreboard bench covering wrap, saturate, full-range and a two-stage cascade.
module tb_updncnt;
    logic       clk = 1'b0;
    logic       resl = 1'b0, ci = 1'b0, dn = 1'b0, ld = 1'b0;
    logic [7:0] d = 8'd0;

    logic [7:0] q_w, q_s, q_f;
    logic [3:0] q_c0, q_c1;
    logic       co_w, co_s, co_f, co_c0, co_c1;
    logic       tcq_w, tcq_s, tcq_f, tcq_c0, tcq_c1;

    always #5 clk = ~clk;

    updncnt #(.WIDTH(8), .TOP(9), .SAT(1'b0)) u_w (
        .clk(clk), .resl(resl), .ci(ci), .dn(dn), .ld(ld), .d(d), .q(q_w), .co(co_w), .tcq(tcq_w));
    updncnt #(.WIDTH(8), .TOP(9), .SAT(1'b1)) u_s (
        .clk(clk), .resl(resl), .ci(ci), .dn(dn), .ld(ld), .d(d), .q(q_s), .co(co_s), .tcq(tcq_s));
    updncnt #(.WIDTH(8)) u_f (
        .clk(clk), .resl(resl), .ci(ci), .dn(dn), .ld(ld), .d(d), .q(q_f), .co(co_f), .tcq(tcq_f));
    updncnt #(.WIDTH(4), .TOP(15)) u_c0 (
        .clk(clk), .resl(resl), .ci(ci), .dn(dn), .ld(ld), .d(d[3:0]), .q(q_c0), .co(co_c0), .tcq(tcq_c0));
    updncnt #(.WIDTH(4), .TOP(15)) u_c1 (
        .clk(clk), .resl(resl), .ci(co_c0), .dn(dn), .ld(ld), .d(d[7:4]), .q(q_c1), .co(co_c1), .tcq(tcq_c1));

    typedef struct packed {
        logic [3:0][7:0] q;
        logic [3:0]      co;
        logic [3:0]      tcq;
    } exp_t;

    exp_t  sb[$];
    int    checks = 0, errors = 0;
    int    m[4]    = '{0, 0, 0, 0};
    bit    t[4]    = '{0, 0, 0, 0};
    int    tops[4] = '{9, 9, 255, 255};
    bit    sats[4] = '{0, 1, 0, 0};
    string nm[4]   = '{"wrap", "sat", "full", "casc"};

    // The cascade of two 4-bit stages behaves as one 8-bit wrapping counter
    function automatic int nxt(int v, int top, bit sat, bit r, bit l, bit c, bit dir, int dv);
        if (!r) return 0;
        if (l) return (dv > top) ? top : dv;
        if (!c) return v;
        if (!dir) return sat ? ((v + 1 > top) ? top : v + 1) : (v + 1) % (top + 1);
        return sat ? ((v == 0) ? 0 : v - 1) : (v + top) % (top + 1);
    endfunction

    function automatic bit hit(int v, int top, bit r, bit l, bit c, bit dir);
        return r && !l && c && (dir ? (v == 0) : (v == top));
    endfunction

    task automatic cyc(input bit r, input bit l, input bit c, input bit dir, input int dv);
        exp_t e;
        @(posedge clk);
        #1;
        resl = r; ld = l; ci = c; dn = dir; d = 8'(dv);
        for (int i = 0; i < 4; i++) begin
            e.q[i]   = 8'(m[i]);
            e.tcq[i] = t[i];
            e.co[i]  = hit(m[i], tops[i], r, l, c, dir);
            t[i]     = r && e.co[i];
            m[i]     = nxt(m[i], tops[i], sats[i], r, l, c, dir, dv);
        end
        sb.push_back(e);
    endtask

    task automatic chk(input string n, input int idx, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s.%s t=%0t got %0d want %0d", nm[idx], n, $time, got, want);
        end
    endtask

    initial begin : monitor
        exp_t e;
        logic [3:0][7:0] qa;
        logic [3:0]      ca, ta;
        forever begin
            @(negedge clk);
            if (sb.size() != 0) begin
                e  = sb.pop_front();
                qa = {{4'd0, q_c1, q_c0}, q_f, q_s, q_w};
                ca = {co_c1, co_f, co_s, co_w};
                ta = {tcq_c1, tcq_f, tcq_s, tcq_w};
                for (int i = 0; i < 4; i++) begin
                    chk("q", i, int'(qa[i]), int'(e.q[i]));
                    chk("co", i, int'(ca[i]), int'(e.co[i]));
                    chk("tcq", i, int'(ta[i]), int'(e.tcq[i]));
                end
            end
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog t=%0t got timeout want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        repeat (3) cyc(0, 0, 1, 0, 0);
        repeat (13) cyc(1, 0, 1, 0, 0);
        cyc(1, 1, 0, 0, 2);
        repeat (6) cyc(1, 0, 1, 1, 0);
        cyc(1, 1, 1, 0, 200);
        cyc(1, 0, 0, 0, 0);
        cyc(0, 0, 1, 0, 0);
        repeat (256) cyc(1, 0, 1, 0, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 9);
        cyc(1, 0, 1, 1, 0);
        cyc(0, 0, 1, 1, 0);
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 0);
        repeat (40) cyc(1, 0, 1, 1, 0);
        for (int k = 0; k < 2000; k++)
            cyc($urandom_range(0, 49) != 0, $urandom_range(0, 19) == 0, $urandom_range(0, 9) != 0,
                ($urandom_range(0, 7) == 0) ? ~dn : dn, int'($urandom_range(0, 255)));
        for (int k = 0; k < 10 && sb.size() != 0; k++) @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain t=%0t got %0d pending want 0", $time, sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
